// File: rtl/sc_spi_target_if.sv
// rtl/sc_spi_target_if.sv - SPI pin and local word bus bundle for sc_spi_target
// master: SPI master plus local host view; slave: the target engine.
interface sc_spi_target_if #(
   parameter int DATA_WIDTH = 8
);
   logic [1:0]            CLK_MODE;
   logic                  SPICLK;
   logic                  SPICSB;
   logic                  SPIMOSI;
   logic                  SPIMISO;
   logic                  SPIMISO_OE;
   logic [DATA_WIDTH-1:0] TX_DATA;
   logic                  TX_VALID;
   logic                  TX_READY;
   logic [DATA_WIDTH-1:0] RX_DATA;
   logic                  RX_VALID;
   logic                  TX_UNDERRUN;

   modport master (
      output CLK_MODE, SPICLK, SPICSB, SPIMOSI, TX_DATA, TX_VALID,
      input  SPIMISO, SPIMISO_OE, TX_READY, RX_DATA, RX_VALID, TX_UNDERRUN
   );

   modport slave (
      input  CLK_MODE, SPICLK, SPICSB, SPIMOSI, TX_DATA, TX_VALID,
      output SPIMISO, SPIMISO_OE, TX_READY, RX_DATA, RX_VALID, TX_UNDERRUN
   );
endinterface

// File: rtl/sc_spi_target.sv
// rtl/sc_spi_target.sv - oversampled SPI target shift engine
// Synchronises the SPI pins to SRCCLK, detects mode-dependent edges, and moves words MSB first.
module sc_spi_target #(
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic           SRCCLK,
   input  logic           SYSRST,
   sc_spi_target_if.slave bus
);
   localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

   typedef enum logic {IDLE, ACTIVE} state_t;
   state_t state, state_next;

   logic [SYNC_STAGES-1:0] clk_sync, csb_sync, mosi_sync;
   logic                   clk_s, csb_s, mosi_s, clk_d;
   logic                   rise, fall, lead_edge, trail_edge, sample_edge, shift_edge;
   logic [1:0]             mode_q;
   logic [CW-1:0]          bit_cnt;
   logic                   hold, load_pend;
   logic [DATA_WIDTH-1:0]  rx_shift, rx_data_q, tx_shift, tx_buf;
   logic                   buf_full, rx_valid_q, underrun_q;
   logic                   start, stop, do_load, do_sample, do_shift, clr_hold;

   always_ff @(posedge SRCCLK) begin
      if (SYSRST) begin
         clk_sync  <= '0;
         csb_sync  <= '1;
         mosi_sync <= '0;
         clk_d     <= 1'b0;
      end else begin
         clk_sync  <= {clk_sync[SYNC_STAGES-2:0], bus.SPICLK};
         csb_sync  <= {csb_sync[SYNC_STAGES-2:0], bus.SPICSB};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.SPIMOSI};
         clk_d     <= clk_s;
      end
   end

   assign clk_s  = clk_sync[SYNC_STAGES-1];
   assign csb_s  = csb_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];

   assign rise        = clk_s & ~clk_d;
   assign fall        = ~clk_s & clk_d;
   assign lead_edge   = mode_q[1] ? fall : rise;
   assign trail_edge  = mode_q[1] ? rise : fall;
   assign sample_edge = mode_q[0] ? trail_edge : lead_edge;
   assign shift_edge  = mode_q[0] ? lead_edge : trail_edge;

   always_ff @(posedge SRCCLK) begin
      if (SYSRST) state <= IDLE;
      else        state <= state_next;
   end

   // Deselect takes priority over any clock edge seen in the same cycle.
   always_comb begin
      state_next = state;
      start      = 1'b0;
      stop       = 1'b0;
      do_load    = 1'b0;
      do_sample  = 1'b0;
      do_shift   = 1'b0;
      clr_hold   = 1'b0;
      case (state)
         IDLE: begin
            if (!csb_s) begin
               state_next = ACTIVE;
               start      = 1'b1;
               do_load    = 1'b1;
            end
         end
         ACTIVE: begin
            if (csb_s) begin
               state_next = IDLE;
               stop       = 1'b1;
            end else begin
               do_sample = sample_edge;
               if (shift_edge) begin
                  if (hold)           clr_hold = 1'b1;
                  else if (load_pend) do_load  = 1'b1;
                  else                do_shift = 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge SRCCLK) begin
      if (SYSRST) begin
         mode_q     <= 2'b00;
         bit_cnt    <= '0;
         hold       <= 1'b0;
         load_pend  <= 1'b0;
         rx_shift   <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         tx_shift   <= '0;
         tx_buf     <= '0;
         buf_full   <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         rx_valid_q <= 1'b0;
         underrun_q <= 1'b0;
         if (start) begin
            mode_q  <= bus.CLK_MODE;
            bit_cnt <= '0;
            hold    <= bus.CLK_MODE[0];
         end
         if (stop) begin
            bit_cnt   <= '0;
            hold      <= 1'b0;
            load_pend <= 1'b0;
         end
         if (clr_hold) hold <= 1'b0;
         if (do_load) begin
            load_pend <= 1'b0;
            if (buf_full) begin
               tx_shift <= tx_buf;
               buf_full <= 1'b0;
            end else begin
               tx_shift   <= '1;
               underrun_q <= 1'b1;
            end
         end else if (do_shift) begin
            tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b1};
         end
         if (do_sample) begin
            rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
            if (bit_cnt == LAST_BIT) begin
               rx_data_q  <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
               rx_valid_q <= 1'b1;
               bit_cnt    <= '0;
               load_pend  <= 1'b1;
            end else begin
               bit_cnt <= bit_cnt + 1'b1;
            end
         end
         // A load that empties the buffer never coincides with an accept, since accept needs it empty.
         if (bus.TX_VALID && !buf_full) begin
            tx_buf   <= bus.TX_DATA;
            buf_full <= 1'b1;
         end
      end
   end

   assign bus.SPIMISO     = (state == ACTIVE) & tx_shift[DATA_WIDTH-1];
   assign bus.SPIMISO_OE  = (state == ACTIVE);
   assign bus.TX_READY    = ~buf_full;
   assign bus.RX_DATA     = rx_data_q;
   assign bus.RX_VALID    = rx_valid_q;
   assign bus.TX_UNDERRUN = underrun_q;
endmodule
